// File: rtl/gravsim_regfile_pkg.sv
// Shared constants, word type and byte-merge helper for the gravity-simulator register file.
// Optional host write lock is enabled by defining GRAVSIM_HOST_LOCK_EN.
package gravsim_pkg;

    localparam int MAX_PLANETS   = 10;
    localparam int NUM_REGS      = 4 + 11 * MAX_PLANETS;
    localparam int NUM_FSM_PORTS = 6;

    localparam int OFFSET_G     = 0;
    localparam int OFFSET_NUM   = 1;
    localparam int OFFSET_START = 2;
    localparam int OFFSET_DONE  = 3;

    // Planet p (1..MAX_PLANETS) lives at OFFSET_x + p
    localparam int OFFSET_MASS  = 3;
    localparam int OFFSET_RAD   = 13;
    localparam int OFFSET_POS_X = 23;
    localparam int OFFSET_POS_Y = 33;
    localparam int OFFSET_POS_Z = 43;
    localparam int OFFSET_VEL_X = 53;
    localparam int OFFSET_VEL_Y = 63;
    localparam int OFFSET_VEL_Z = 73;
    localparam int OFFSET_ACC_X = 83;
    localparam int OFFSET_ACC_Y = 93;
    localparam int OFFSET_ACC_Z = 103;

    localparam int ACC_LO  = OFFSET_ACC_X + 1;
    localparam int ACC_HI  = OFFSET_ACC_Z + MAX_PLANETS;
    localparam int LOCK_LO = OFFSET_MASS + 1;

    typedef logic [31:0] word_t;

    function automatic word_t byte_merge(input word_t old_word, input word_t new_word,
                                         input logic [3:0] byte_en);
        return {byte_en[3] ? new_word[31:24] : old_word[31:24],
                byte_en[2] ? new_word[23:16] : old_word[23:16],
                byte_en[1] ? new_word[15:8]  : old_word[15:8],
                byte_en[0] ? new_word[7:0]   : old_word[7:0]};
    endfunction

endpackage

// File: rtl/gravsim_regfile_if.sv
// Avalon-MM slave bus between the NIOS host and the register file.
// Used identically with or without GRAVSIM_HOST_LOCK_EN.
interface gravsim_regfile_if;
    import gravsim_pkg::*;

    logic       AVL_CS;
    logic       AVL_READ;
    logic       AVL_WRITE;
    logic [6:0] AVL_ADDR;
    logic [3:0] AVL_BYTE_EN;
    word_t      AVL_WRITEDATA;
    word_t      AVL_READDATA;

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        output AVL_READDATA
    );

endinterface

// File: rtl/gravsim_regfile_word_wr_sel.sv
// One register-file word: picks its next value from reset, clear_accs, START/DONE
// handshake, the six FSM write ports and the host byte write. Unaffected by GRAVSIM_HOST_LOCK_EN.
module gravsim_word_wr_sel
    import gravsim_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_accs,
    input  logic                        fsm_done,
    input  logic [1:0]                  fsm_we,
    input  word_t [NUM_FSM_PORTS-1:0]   fsm_addr,
    input  word_t [NUM_FSM_PORTS-1:0]   fsm_data,
    input  logic                        host_we,
    input  logic                        host_start_set,
    input  logic [3:0]                  byte_en,
    input  word_t                       writedata,
    output word_t                       q
);

    localparam bit IS_ACC   = (IDX >= ACC_LO) && (IDX <= ACC_HI);
    localparam bit IS_START = (IDX == OFFSET_START);
    localparam bit IS_DONE  = (IDX == OFFSET_DONE);

    logic [NUM_FSM_PORTS-1:0] port_en;
    logic [NUM_FSM_PORTS-1:0] hit;
    logic                     fsm_hit;
    word_t                    fsm_value;
    word_t                    nxt;

    assign port_en = {{3{fsm_we[1]}}, {3{fsm_we[0]}}};

    // Full 32-bit compare so out-of-range FSM addresses never alias onto a word
    for (genvar n = 0; n < NUM_FSM_PORTS; n++) begin : g_hit
        assign hit[n] = port_en[n] && (fsm_addr[n] == word_t'(IDX));
    end

    assign fsm_hit = |hit;

    always_comb begin
        fsm_value = fsm_data[0];
        if (hit[1]) fsm_value = fsm_data[1];
        if (hit[2]) fsm_value = fsm_data[2];
        if (hit[3]) fsm_value = fsm_data[3];
        if (hit[4]) fsm_value = fsm_data[4];
        if (hit[5]) fsm_value = fsm_data[5];
    end

    // Later assignments override earlier ones, giving the priority order low to high
    always_comb begin
        nxt = q;
        if (host_we)                   nxt = byte_merge(q, writedata, byte_en);
        if (IS_DONE && host_start_set) nxt = '0;
        if (fsm_hit)                   nxt = fsm_value;
        if (IS_ACC && clear_accs)      nxt = '0;
        if (IS_START && fsm_done)      nxt = '0;
        if (IS_DONE && fsm_done)       nxt = 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= nxt;
    end

endmodule

// File: rtl/gravsim_regfile.sv
// Shared host/FSM register file for the gravity simulator, exposed whole as datafile.
// Define GRAVSIM_HOST_LOCK_EN to block host writes above the handshake words while a run is active.
module gravsim_regfile
    import gravsim_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    gravsim_regfile_if.slave       avl,
    output logic                   FSM_START,
    input  logic                   FSM_DONE,
    input  logic                   clear_accs,
    input  logic [1:0]             FSM_we,
    input  word_t                  ADDR1,
    input  word_t                  ADDR2,
    input  word_t                  ADDR3,
    input  word_t                  ADDR4,
    input  word_t                  ADDR5,
    input  word_t                  ADDR6,
    input  word_t                  DATA1,
    input  word_t                  DATA2,
    input  word_t                  DATA3,
    input  word_t                  DATA4,
    input  word_t                  DATA5,
    input  word_t                  DATA6,
    output word_t [NUM_REGS-1:0]   datafile
);

    word_t [NUM_REGS-1:0]      regs;
    word_t [NUM_FSM_PORTS-1:0] fsm_addr;
    word_t [NUM_FSM_PORTS-1:0] fsm_data;
    logic                      addr_ok;
    logic                      host_lock;
    logic                      host_wr_ok;
    logic                      host_start_set;

    assign fsm_addr = {ADDR6, ADDR5, ADDR4, ADDR3, ADDR2, ADDR1};
    assign fsm_data = {DATA6, DATA5, DATA4, DATA3, DATA2, DATA1};

    assign addr_ok = avl.AVL_ADDR < 7'(NUM_REGS);

`ifdef GRAVSIM_HOST_LOCK_EN
    assign host_lock = FSM_START && (avl.AVL_ADDR >= 7'(LOCK_LO));
`else
    assign host_lock = 1'b0;
`endif

    assign host_wr_ok = avl.AVL_CS && avl.AVL_WRITE && addr_ok && !host_lock;

    // A host START request also re-arms DONE so the host can poll for the new run
    assign host_start_set = host_wr_ok && (avl.AVL_ADDR == 7'(OFFSET_START))
                            && avl.AVL_BYTE_EN[0] && avl.AVL_WRITEDATA[0];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        gravsim_word_wr_sel #(
            .IDX(i)
        ) u_word (
            .clk            (CLK),
            .reset          (RESET),
            .clear_accs     (clear_accs),
            .fsm_done       (FSM_DONE),
            .fsm_we         (FSM_we),
            .fsm_addr       (fsm_addr),
            .fsm_data       (fsm_data),
            .host_we        (host_wr_ok && (avl.AVL_ADDR == 7'(i))),
            .host_start_set (host_start_set),
            .byte_en        (avl.AVL_BYTE_EN),
            .writedata      (avl.AVL_WRITEDATA),
            .q              (regs[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            avl.AVL_READDATA <= '0;
        end else if (avl.AVL_CS && avl.AVL_READ) begin
            avl.AVL_READDATA <= addr_ok ? regs[avl.AVL_ADDR] : '0;
        end
    end

    assign FSM_START = regs[OFFSET_START][0];
    assign datafile  = regs;

endmodule

// File: tb/tb_gravsim_regfile.sv
// Directed testbench for gravsim_regfile; expectations adapt to GRAVSIM_HOST_LOCK_EN.
module tb_gravsim_regfile;
    import gravsim_pkg::*;

`ifdef GRAVSIM_HOST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic                 FSM_START;
    logic                 FSM_DONE;
    logic                 clear_accs;
    logic [1:0]           FSM_we;
    word_t                ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
    word_t                DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
    word_t [NUM_REGS-1:0] datafile;

    int total = 0;
    int bad   = 0;

    gravsim_regfile_if avl_bus ();

    gravsim_regfile dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .avl        (avl_bus),
        .FSM_START  (FSM_START),
        .FSM_DONE   (FSM_DONE),
        .clear_accs (clear_accs),
        .FSM_we     (FSM_we),
        .ADDR1      (ADDR1),
        .ADDR2      (ADDR2),
        .ADDR3      (ADDR3),
        .ADDR4      (ADDR4),
        .ADDR5      (ADDR5),
        .ADDR6      (ADDR6),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .DATA3      (DATA3),
        .DATA4      (DATA4),
        .DATA5      (DATA5),
        .DATA6      (DATA6),
        .datafile   (datafile)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       is_read;
        logic [6:0] addr;
        logic [3:0] be;
        word_t      data;
        word_t      expv;
    } vec_t;

    vec_t vecs [0:15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input word_t act, input word_t expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic host_write(input logic [6:0] a, input logic [3:0] be, input word_t d);
        avl_bus.AVL_CS        = 1'b1;
        avl_bus.AVL_WRITE     = 1'b1;
        avl_bus.AVL_ADDR      = a;
        avl_bus.AVL_BYTE_EN   = be;
        avl_bus.AVL_WRITEDATA = d;
        tick();
        avl_bus.AVL_CS        = 1'b0;
        avl_bus.AVL_WRITE     = 1'b0;
    endtask

    task automatic host_read(input logic [6:0] a, output word_t d);
        avl_bus.AVL_CS   = 1'b1;
        avl_bus.AVL_READ = 1'b1;
        avl_bus.AVL_ADDR = a;
        tick();
        avl_bus.AVL_CS   = 1'b0;
        avl_bus.AVL_READ = 1'b0;
        d = avl_bus.AVL_READDATA;
    endtask

    task automatic fsm_idle();
        FSM_DONE   = 1'b0;
        clear_accs = 1'b0;
        FSM_we     = 2'b00;
        ADDR1 = '1; ADDR2 = '1; ADDR3 = '1; ADDR4 = '1; ADDR5 = '1; ADDR6 = '1;
        DATA1 = '0; DATA2 = '0; DATA3 = '0; DATA4 = '0; DATA5 = '0; DATA6 = '0;
    endtask

    task automatic check_all_zero(input string name);
        int nz;
        nz = 0;
        for (int w = 0; w < NUM_REGS; w++) if (datafile[w] != '0) nz++;
        check(name, 32'(nz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        word_t rd;
        word_t exp_locked;

        vecs[0]  = '{1'b0, 7'd0,   4'b0011, 32'h4080_0000, 32'h0};
        vecs[1]  = '{1'b1, 7'd0,   4'b0000, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 7'd0,   4'b1100, 32'h4080_0000, 32'h0};
        vecs[3]  = '{1'b1, 7'd0,   4'b0000, 32'h0,         32'h4080_0000};
        vecs[4]  = '{1'b0, 7'd1,   4'b1111, 32'h0000_0003, 32'h0};
        vecs[5]  = '{1'b1, 7'd1,   4'b0000, 32'h0,         32'h0000_0003};
        vecs[6]  = '{1'b0, 7'd5,   4'b0001, 32'hAABB_CCDD, 32'h0};
        vecs[7]  = '{1'b1, 7'd5,   4'b0000, 32'h0,         32'h0000_00DD};
        vecs[8]  = '{1'b0, 7'd5,   4'b0100, 32'h1122_3344, 32'h0};
        vecs[9]  = '{1'b1, 7'd5,   4'b0000, 32'h0,         32'h0022_00DD};
        vecs[10] = '{1'b0, 7'd113, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b1, 7'd113, 4'b0000, 32'h0,         32'h1234_5678};
        vecs[12] = '{1'b0, 7'd114, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[13] = '{1'b1, 7'd114, 4'b0000, 32'h0,         32'h0000_0000};
        vecs[14] = '{1'b0, 7'd127, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[15] = '{1'b1, 7'd0,   4'b0000, 32'h0,         32'h4080_0000};

        avl_bus.AVL_CS        = 1'b0;
        avl_bus.AVL_READ      = 1'b0;
        avl_bus.AVL_WRITE     = 1'b0;
        avl_bus.AVL_ADDR      = '0;
        avl_bus.AVL_BYTE_EN   = '0;
        avl_bus.AVL_WRITEDATA = '0;
        fsm_idle();

        // Power-on reset
        RESET = 1'b1;
        tick();
        tick();
        check("reset_start", 32'(FSM_START), 32'd0);
        check("reset_rdata", avl_bus.AVL_READDATA, 32'd0);
        check_all_zero("reset_words");
        RESET = 1'b0;

        // Host byte-enable writes and reads from the table
        for (int i = 0; i <= 15; i++) begin
            if (vecs[i].is_read) begin
                host_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].expv);
            end else begin
                host_write(vecs[i].addr, vecs[i].be, vecs[i].data);
            end
        end
        check("datafile0", datafile[0], 32'h4080_0000);
        check("datafile113", datafile[113], 32'h1234_5678);

        // Read and write of the same word in one cycle returns the old value
        avl_bus.AVL_CS        = 1'b1;
        avl_bus.AVL_READ      = 1'b1;
        avl_bus.AVL_WRITE     = 1'b1;
        avl_bus.AVL_ADDR      = 7'd6;
        avl_bus.AVL_BYTE_EN   = 4'hF;
        avl_bus.AVL_WRITEDATA = 32'h0000_0055;
        tick();
        avl_bus.AVL_CS    = 1'b0;
        avl_bus.AVL_READ  = 1'b0;
        avl_bus.AVL_WRITE = 1'b0;
        check("rw_same_old", avl_bus.AVL_READDATA, 32'h0);
        host_read(7'd6, rd);
        check("rw_same_new", rd, 32'h0000_0055);
        tick();
        tick();
        check("rdata_hold", avl_bus.AVL_READDATA, 32'h0000_0055);

        // START/DONE handshake
        host_write(7'd2, 4'hF, 32'd1);
        check("start_set", 32'(FSM_START), 32'd1);
        FSM_DONE = 1'b1;
        tick();
        FSM_DONE = 1'b0;
        check("done_word", datafile[3], 32'd1);
        check("start_drop", 32'(FSM_START), 32'd0);
        host_read(7'd3, rd);
        check("done_read", rd, 32'd1);
        host_write(7'd2, 4'hF, 32'd1);
        check("restart_clr_done", datafile[3], 32'd0);
        check("restart_start", 32'(FSM_START), 32'd1);
        FSM_DONE = 1'b1;
        host_write(7'd2, 4'hF, 32'd1);
        FSM_DONE = 1'b0;
        check("done_beats_host_start", 32'(FSM_START), 32'd0);
        check("done_beats_host_done", datafile[3], 32'd1);

        // FSM port priority, out-of-range drop, we-bit grouping
        FSM_we = 2'b11;
        ADDR1 = 32'd24;        DATA1 = 32'h3F80_0000;
        ADDR6 = 32'd24;        DATA6 = 32'hBF80_0000;
        ADDR2 = 32'h0000_0099; DATA2 = 32'h0000_DEAD;
        ADDR3 = 32'h0000_011A; DATA3 = 32'h0000_BEEF;
        host_write(7'd24, 4'hF, 32'h0);
        fsm_idle();
        check("port6_wins", datafile[24], 32'hBF80_0000);
        check("oor_drop_25", datafile[25], 32'h0);
        check("oor_drop_26", datafile[26], 32'h0);

        FSM_we = 2'b01;
        ADDR1 = 32'd30; DATA1 = 32'h0000_000A;
        ADDR4 = 32'd31; DATA4 = 32'h0000_000B;
        ADDR2 = 32'd35; DATA2 = 32'h0000_0002;
        ADDR3 = 32'd35; DATA3 = 32'h0000_0003;
        tick();
        fsm_idle();
        check("we0_port1", datafile[30], 32'h0000_000A);
        check("we0_port4_off", datafile[31], 32'h0);
        check("port3_beats_2", datafile[35], 32'h0000_0003);

        FSM_we = 2'b10;
        ADDR1 = 32'd32; DATA1 = 32'h0000_000C;
        ADDR5 = 32'd33; DATA5 = 32'h0000_000D;
        tick();
        fsm_idle();
        check("we1_port1_off", datafile[32], 32'h0);
        check("we1_port5", datafile[33], 32'h0000_000D);

        // clear_accs wipes exactly the ACC region and beats an FSM write into it
        for (int w = ACC_LO; w <= ACC_HI; w++) host_write(7'(w), 4'hF, 32'h3F80_0000);
        host_write(7'd64, 4'hF, 32'h3F80_0000);
        host_write(7'd83, 4'hF, 32'h3F80_0000);
        check("acc_loaded", datafile[ACC_HI], 32'h3F80_0000);
        clear_accs = 1'b1;
        FSM_we = 2'b01;
        ADDR1 = 32'd84; DATA1 = 32'h0000_1234;
        host_write(7'd90, 4'hF, 32'h0000_0007);
        fsm_idle();
        for (int w = ACC_LO; w <= ACC_HI; w++) check($sformatf("acc_clr%0d", w), datafile[w], 32'h0);
        check("vel_y1_kept", datafile[64], 32'h3F80_0000);
        check("word83_kept", datafile[83], 32'h3F80_0000);

        // Host writes while a run is active
        exp_locked = LOCK ? 32'hBF80_0000 : 32'd5;
        host_write(7'd2, 4'hF, 32'd1);
        check("lock_start", 32'(FSM_START), 32'd1);
        host_write(7'd24, 4'hF, 32'd5);
        check("lock_w24", datafile[24], exp_locked);
        host_write(7'd4, 4'hF, 32'd9);
        check("lock_w4", datafile[4], LOCK ? 32'd0 : 32'd9);
        host_write(7'd0, 4'hF, 32'd5);
        check("lock_w0", datafile[0], 32'd5);
        host_read(7'd24, rd);
        check("lock_read24", rd, exp_locked);

        // Reset during a run aborts without setting DONE
        host_read(7'd0, rd);
        check("pre_reset_read", rd, 32'd5);
        RESET = 1'b1;
        FSM_DONE = 1'b1;
        tick();
        RESET = 1'b0;
        FSM_DONE = 1'b0;
        check("midrun_start", 32'(FSM_START), 32'd0);
        check("midrun_done", datafile[3], 32'd0);
        check("midrun_rdata", avl_bus.AVL_READDATA, 32'd0);
        check_all_zero("midrun_words");
        host_read(7'd0, rd);
        check("post_reset_r0", rd, 32'd0);
        host_read(7'd2, rd);
        check("post_reset_r2", rd, 32'd0);
        host_read(7'd113, rd);
        check("post_reset_r113", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
